audio_frame_windower: RTL and testbench

Downstream stage of the microphone sample shift register. Counts new-sample strobes and, every HOP new samples, snapshots the 16-tap sample window (oldest to newest). It applies a 16-point Hann window in Q1.15 fixed point and streams the 16 windowed words to the FFT input over a valid/ready handshake. A frame that arrives while a stream is in progress is dropped and flagged, so the FFT always receives complete, coherent frames.

---
 rtl/audio_pkg.sv | 26 ++
 rtl/audio_frame_windower_mul.sv | 23 ++
 rtl/audio_frame_windower.sv | 148 ++++++++++++++
 tb/tb_audio_frame_windower.sv | 279 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/audio_pkg.sv
// Shared types and constants for the audio frame windower: sample type,
// frame length, the Q1.15 Hann table and the streaming FSM states.
package audio_pkg;

    typedef logic signed [17:0] sample_t;

    localparam int FRAME_LEN = 16;

    // round(32767 * 0.5 * (1 - cos(2*pi*n/15))); symmetric, zero at both ends
    localparam logic [15:0] HANN_Q15 [0:15] = '{
        16'd0,     16'd1416,  16'd5421,  16'd11321,
        16'd18096, 16'd24575, 16'd29638, 16'd32409,
        16'd32409, 16'd29638, 16'd24575, 16'd18096,
        16'd11321, 16'd5421,  16'd1416,  16'd0
    };

    typedef enum logic {
        IDLE   = 1'b0,
        STREAM = 1'b1
    } state_e;

    function automatic logic [15:0] hann_coef(input logic [3:0] idx);
        return HANN_Q15[idx];
    endfunction

endpackage

// File: rtl/audio_frame_windower_mul.sv
// Combinational signed 18-bit sample times unsigned Q1.15 coefficient,
// rounded half-up and truncated back to 18 bits.
module q15_window_mul
    import audio_pkg::*;
(
    input  sample_t     sample_i,
    input  logic [15:0] coef_i,
    output sample_t     result_o
);

    logic signed [34:0] sample_ext;
    logic signed [34:0] coef_ext;
    logic signed [34:0] prod;
    logic signed [34:0] sum;

    assign sample_ext = {{17{sample_i[17]}}, sample_i};
    assign coef_ext   = $signed({19'd0, coef_i});
    assign prod       = sample_ext * coef_ext;
    assign sum        = prod + 35'sd16384;
    // Coefficients stay below 1.0, so the shifted value always fits 18 bits
    assign result_o   = 18'(sum >>> 15);

endmodule

// File: rtl/audio_frame_windower.sv
// Captures a 16-tap sample window every HOP strobes and streams it,
// optionally Hann-windowed, over valid/ready; frames arriving mid-stream drop.
module audio_frame_windower
    import audio_pkg::*;
#(
    parameter int HOP       = 8,
    parameter int WINDOW_EN = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        new_t,
    input  sample_t     t0,
    input  sample_t     t1,
    input  sample_t     t2,
    input  sample_t     t3,
    input  sample_t     t4,
    input  sample_t     t5,
    input  sample_t     t6,
    input  sample_t     t7,
    input  sample_t     t8,
    input  sample_t     t9,
    input  sample_t     t10,
    input  sample_t     t11,
    input  sample_t     t12,
    input  sample_t     t13,
    input  sample_t     t14,
    input  sample_t     t15,
    output sample_t     s_data,
    output logic [3:0]  s_idx,
    output logic        s_last,
    output logic        s_valid,
    input  logic        s_ready,
    output logic        busy,
    output logic        overrun
);

    // Handshake: a word transfers in any cycle where s_valid && s_ready are
    // both high at the rising edge; while stalled the word is held unchanged.

    state_e      state_q;
    logic [3:0]  hop_cnt_q;
    logic [4:0]  rd_idx_q;
    sample_t     snap_q [FRAME_LEN];
    sample_t     s_data_q;
    logic [3:0]  s_idx_q;
    logic        s_last_q;
    logic        s_valid_q;
    logic        overrun_q;

    sample_t     taps [FRAME_LEN];
    logic        capture;
    logic        last_hs;
    logic        load;
    logic [3:0]  rd_ptr;
    sample_t     win_out;
    sample_t     s_data_d;

    always_comb begin
        taps[0]  = t0;
        taps[1]  = t1;
        taps[2]  = t2;
        taps[3]  = t3;
        taps[4]  = t4;
        taps[5]  = t5;
        taps[6]  = t6;
        taps[7]  = t7;
        taps[8]  = t8;
        taps[9]  = t9;
        taps[10] = t10;
        taps[11] = t11;
        taps[12] = t12;
        taps[13] = t13;
        taps[14] = t14;
        taps[15] = t15;
    end

    assign capture = new_t && (hop_cnt_q == 4'(HOP - 1));
    assign last_hs = s_valid_q && s_ready && s_last_q;
    // rd_idx_q[4] marks that all sixteen words have already been loaded
    assign load    = (state_q == STREAM) && !rd_idx_q[4] && (!s_valid_q || s_ready);
    assign rd_ptr  = rd_idx_q[3:0];

    q15_window_mul u_mul (
        .sample_i (snap_q[rd_ptr]),
        .coef_i   (hann_coef(rd_ptr)),
        .result_o (win_out)
    );

    assign s_data_d = (WINDOW_EN != 0) ? win_out : snap_q[rd_ptr];

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            hop_cnt_q <= '0;
            rd_idx_q  <= '0;
            s_data_q  <= '0;
            s_idx_q   <= '0;
            s_last_q  <= 1'b0;
            s_valid_q <= 1'b0;
            overrun_q <= 1'b0;
            for (int i = 0; i < FRAME_LEN; i++) snap_q[i] <= '0;
        end else begin
            if (new_t) hop_cnt_q <= capture ? 4'd0 : hop_cnt_q + 4'd1;

            if (load) begin
                s_data_q  <= s_data_d;
                s_idx_q   <= rd_ptr;
                s_last_q  <= (rd_ptr == 4'd15);
                s_valid_q <= 1'b1;
                rd_idx_q  <= rd_idx_q + 5'd1;
            end else if (s_ready) begin
                s_valid_q <= 1'b0;
            end

            case (state_q)
                IDLE: begin
                    if (capture) begin
                        for (int i = 0; i < FRAME_LEN; i++) snap_q[i] <= taps[FRAME_LEN-1-i];
                        rd_idx_q <= '0;
                        state_q  <= STREAM;
                    end
                end
                STREAM: begin
                    if (last_hs) begin
                        // A capture coinciding with the final handshake starts the next frame
                        if (capture) begin
                            for (int i = 0; i < FRAME_LEN; i++) snap_q[i] <= taps[FRAME_LEN-1-i];
                            rd_idx_q <= '0;
                        end else begin
                            state_q <= IDLE;
                        end
                    end else if (capture) begin
                        overrun_q <= 1'b1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign s_data  = s_data_q;
    assign s_idx   = s_idx_q;
    assign s_last  = s_last_q;
    assign s_valid = s_valid_q;
    assign overrun = overrun_q;
    assign busy    = (state_q == STREAM) || s_valid_q;

endmodule

// File: tb/tb_audio_frame_windower.sv
// Directed, table-driven bench for audio_frame_windower using three
// parameterisations: bypass HOP=8, windowed HOP=8 and bypass HOP=1.
module tb_audio_frame_windower;

    typedef struct {
        int tap;
        int exp_w;
    } vec_t;

    logic               clk = 1'b0;
    logic               reset;
    logic               new_t;
    logic               s_ready;
    logic signed [17:0] t [16];

    logic signed [17:0] o_data  [3];
    logic [3:0]         o_idx   [3];
    logic               o_last  [3];
    logic               o_valid [3];
    logic               o_busy  [3];
    logic               o_ovr   [3];

    int   n_tests = 0;
    int   n_fail  = 0;
    vec_t cur_tbl [16];
    vec_t mix_tbl [16];
    vec_t neg_tbl [16];

    always #5 clk = ~clk;

    audio_frame_windower #(.HOP(8), .WINDOW_EN(0)) dut0 (
        .clk(clk), .reset(reset), .new_t(new_t),
        .t0(t[0]), .t1(t[1]), .t2(t[2]), .t3(t[3]), .t4(t[4]), .t5(t[5]),
        .t6(t[6]), .t7(t[7]), .t8(t[8]), .t9(t[9]), .t10(t[10]), .t11(t[11]),
        .t12(t[12]), .t13(t[13]), .t14(t[14]), .t15(t[15]),
        .s_data(o_data[0]), .s_idx(o_idx[0]), .s_last(o_last[0]),
        .s_valid(o_valid[0]), .s_ready(s_ready), .busy(o_busy[0]), .overrun(o_ovr[0])
    );

    audio_frame_windower #(.HOP(8), .WINDOW_EN(1)) dut1 (
        .clk(clk), .reset(reset), .new_t(new_t),
        .t0(t[0]), .t1(t[1]), .t2(t[2]), .t3(t[3]), .t4(t[4]), .t5(t[5]),
        .t6(t[6]), .t7(t[7]), .t8(t[8]), .t9(t[9]), .t10(t[10]), .t11(t[11]),
        .t12(t[12]), .t13(t[13]), .t14(t[14]), .t15(t[15]),
        .s_data(o_data[1]), .s_idx(o_idx[1]), .s_last(o_last[1]),
        .s_valid(o_valid[1]), .s_ready(s_ready), .busy(o_busy[1]), .overrun(o_ovr[1])
    );

    audio_frame_windower #(.HOP(1), .WINDOW_EN(0)) dut2 (
        .clk(clk), .reset(reset), .new_t(new_t),
        .t0(t[0]), .t1(t[1]), .t2(t[2]), .t3(t[3]), .t4(t[4]), .t5(t[5]),
        .t6(t[6]), .t7(t[7]), .t8(t[8]), .t9(t[9]), .t10(t[10]), .t11(t[11]),
        .t12(t[12]), .t13(t[13]), .t14(t[14]), .t15(t[15]),
        .s_data(o_data[2]), .s_idx(o_idx[2]), .s_last(o_last[2]),
        .s_valid(o_valid[2]), .s_ready(s_ready), .busy(o_busy[2]), .overrun(o_ovr[2])
    );

    task automatic chk(input string name, input int act, input int exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Inputs change and outputs are observed 1 time unit after each rising edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input int n);
        reset = 1'b1;
        new_t = 1'b0;
        repeat (n) tick();
        reset = 1'b0;
    endtask

    task automatic set_taps_lin(input int base);
        for (int n = 0; n < 16; n++) t[n] = 18'(base + n);
    endtask

    // Eight strobes; returns in the cycle after the capture cycle (C+1)
    task automatic capture8();
        for (int i = 0; i < 8; i++) begin
            new_t = 1'b1;
            tick();
            new_t = 1'b0;
            if (i < 7) tick();
        end
    endtask

    task automatic run_table(input string tag);
        do_reset(2);
        s_ready = 1'b1;
        for (int k = 0; k < 16; k++) t[15-k] = 18'(cur_tbl[k].tap);
        capture8();
        tick();
        for (int k = 0; k < 16; k++) begin
            chk($sformatf("%s_valid[%0d]", tag, k), int'(o_valid[1]), 1);
            chk($sformatf("%s_idx[%0d]", tag, k), int'(o_idx[1]), k);
            chk($sformatf("%s_win[%0d]", tag, k), int'(o_data[1]), cur_tbl[k].exp_w);
            chk($sformatf("%s_byp[%0d]", tag, k), int'(o_data[0]), cur_tbl[k].tap);
            tick();
        end
        chk({tag, "_end_valid"}, int'(o_valid[1]), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : main
        int hs, last_cnt, seen;
        logic               have_prev;
        logic signed [17:0] prev_data;
        logic [3:0]         prev_idx;
        logic               prev_last;

        mix_tbl = '{
            '{5000, 0},      '{32768, 1416},   '{-32768, -5421}, '{1, 0},
            '{2, 1},         '{-1, -1},        '{65536, 59276},  '{131071, 129635},
            '{-131072, -129636}, '{100, 90},   '{-100, -75},     '{16384, 9048},
            '{3, 1},         '{-3, 0},         '{7, 0},          '{77777, 0}
        };
        neg_tbl = '{
            '{-131072, 0},       '{-131072, -5664},   '{-131072, -21684},  '{-131072, -45284},
            '{-131072, -72384},  '{-131072, -98300},  '{-131072, -118552}, '{-131072, -129636},
            '{-131072, -129636}, '{-131072, -118552}, '{-131072, -98300},  '{-131072, -72384},
            '{-131072, -45284},  '{-131072, -21684},  '{-131072, -5664},   '{-131072, 0}
        };

        s_ready = 1'b0;
        set_taps_lin(0);

        // Reset, then idle
        do_reset(3);
        for (int d = 0; d < 3; d++) begin
            chk($sformatf("rst_data[%0d]", d), int'(o_data[d]), 0);
            chk($sformatf("rst_idx[%0d]", d), int'(o_idx[d]), 0);
            chk($sformatf("rst_last[%0d]", d), int'(o_last[d]), 0);
            chk($sformatf("rst_valid[%0d]", d), int'(o_valid[d]), 0);
            chk($sformatf("rst_busy[%0d]", d), int'(o_busy[d]), 0);
            chk($sformatf("rst_ovr[%0d]", d), int'(o_ovr[d]), 0);
        end
        repeat (100) tick();
        for (int d = 0; d < 3; d++) begin
            chk($sformatf("idle_valid[%0d]", d), int'(o_valid[d]), 0);
            chk($sformatf("idle_busy[%0d]", d), int'(o_busy[d]), 0);
        end

        // Bypass stream with latency and throughput
        do_reset(2);
        set_taps_lin(100);
        s_ready = 1'b1;
        capture8();
        chk("byp_c1_valid", int'(o_valid[0]), 0);
        chk("byp_c1_busy", int'(o_busy[0]), 1);
        for (int k = 0; k < 16; k++) begin
            tick();
            chk($sformatf("byp_valid[%0d]", k), int'(o_valid[0]), 1);
            chk($sformatf("byp_idx[%0d]", k), int'(o_idx[0]), k);
            chk($sformatf("byp_data[%0d]", k), int'(o_data[0]), 115 - k);
            chk($sformatf("byp_last[%0d]", k), int'(o_last[0]), (k == 15) ? 1 : 0);
        end
        tick();
        chk("byp_c18_valid", int'(o_valid[0]), 0);
        chk("byp_c18_busy", int'(o_busy[0]), 0);

        // Window arithmetic tables
        cur_tbl = mix_tbl;
        run_table("mix");
        cur_tbl = neg_tbl;
        run_table("neg");

        // Backpressure at 1/3 ready duty
        do_reset(2);
        set_taps_lin(100);
        s_ready = 1'b0;
        capture8();
        hs = 0;
        last_cnt = 0;
        have_prev = 1'b0;
        prev_data = '0;
        prev_idx = '0;
        prev_last = 1'b0;
        for (int cyc = 0; cyc < 200 && hs < 16; cyc++) begin
            s_ready = (cyc % 3 == 0);
            if (have_prev) begin
                chk("bp_hold_data", int'(o_data[0]), int'(prev_data));
                chk("bp_hold_idx", int'(o_idx[0]), int'(prev_idx));
                chk("bp_hold_last", int'(o_last[0]), int'(prev_last));
                chk("bp_hold_valid", int'(o_valid[0]), 1);
            end
            if (o_valid[0] && s_ready) begin
                chk($sformatf("bp_idx[%0d]", hs), int'(o_idx[0]), hs);
                chk($sformatf("bp_data[%0d]", hs), int'(o_data[0]), 115 - hs);
                if (o_last[0]) last_cnt++;
                hs++;
            end
            have_prev = o_valid[0] && !s_ready;
            prev_data = o_data[0];
            prev_idx  = o_idx[0];
            prev_last = o_last[0];
            tick();
        end
        chk("bp_handshakes", hs, 16);
        chk("bp_last_count", last_cnt, 1);
        s_ready = 1'b1;
        tick();
        chk("bp_after_valid", int'(o_valid[0]), 0);

        // Overrun with HOP=1 and a stalled consumer
        do_reset(2);
        set_taps_lin(100);
        s_ready = 1'b0;
        new_t = 1'b1;
        tick();
        chk("ovr_first_capture", int'(o_ovr[2]), 0);
        set_taps_lin(500);
        tick();
        chk("ovr_set", int'(o_ovr[2]), 1);
        chk("ovr_valid", int'(o_valid[2]), 1);
        chk("ovr_busy", int'(o_busy[2]), 1);
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("ovr_hold_idx[%0d]", i), int'(o_idx[2]), 0);
            chk($sformatf("ovr_hold_data[%0d]", i), int'(o_data[2]), 115);
            tick();
        end
        new_t = 1'b0;
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("ovr_cleared", int'(o_ovr[2]), 0);
        chk("ovr_rst_valid", int'(o_valid[2]), 0);

        // Capture coinciding with the final handshake
        do_reset(2);
        set_taps_lin(100);
        s_ready = 1'b1;
        capture8();
        for (int r = 1; r <= 17; r++) begin
            new_t = (r >= 10);
            if (r == 5) set_taps_lin(200);
            if (r >= 2) chk($sformatf("edge_idx[r%0d]", r), int'(o_idx[0]), r - 2);
            tick();
        end
        new_t = 1'b0;
        chk("edge_r18_valid", int'(o_valid[0]), 0);
        chk("edge_r18_busy", int'(o_busy[0]), 1);
        chk("edge_r18_ovr", int'(o_ovr[0]), 0);
        tick();
        chk("edge_r19_valid", int'(o_valid[0]), 1);
        chk("edge_r19_idx", int'(o_idx[0]), 0);
        chk("edge_r19_data", int'(o_data[0]), 215);

        // Reset in the middle of that second frame
        repeat (3) tick();
        chk("mid_pre_valid", int'(o_valid[0]), 1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("mid_rst_valid", int'(o_valid[0]), 0);
        chk("mid_rst_busy", int'(o_busy[0]), 0);
        chk("mid_rst_last", int'(o_last[0]), 0);
        seen = 0;
        for (int i = 0; i < 30; i++) begin
            if (o_valid[0] || o_last[0]) seen++;
            tick();
        end
        chk("mid_no_words_after_reset", seen, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
